bus_decoder: RTL and testbench

- Parametrised address decoder and read-data interconnect between the 6502 core and NSLV memory-mapped slaves (RAM, ROM, timer, UART, future peripherals).
- Each slave gets a base/mask window and a programmable wait-state count.
- The block drives the CPU RDY line to stretch slow accesses and gates write strobes so each access writes exactly once.
- Unmapped accesses return open-bus data and latch a sticky error with the faulting address.

---
 rtl/bus_decoder.sv | 161 ++++++++++++++++
 tb/tb_bus_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bus_decoder.sv
// Address decoder and read-data mux between the 6502 core and NSLV memory-mapped slaves.
// Stretches slow accesses through RDY and flags accesses that hit no slave window.
module bus_decoder #(
  parameter int unsigned NSLV   = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter logic [NSLV*ADDR_W-1:0] BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0] MASK = '0,
  parameter logic [NSLV*4-1:0]      WAIT = '0,
  parameter logic [DATA_W-1:0]      OPEN_BUS = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      dbw,
  input  logic                   we,
  output logic                   rdy,
  output logic [DATA_W-1:0]      dbr,
  output logic [NSLV-1:0]        slv_sel,
  output logic [NSLV-1:0]        slv_we,
  input  logic [NSLV*DATA_W-1:0] slv_dbr,
  output logic                   err,
  output logic [ADDR_W-1:0]      err_addr,
  input  logic                   err_clr
);

  localparam int unsigned IdxW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                sel_vld_q, sel_vld_d;
  logic [IdxW-1:0]     sel_idx_q, sel_idx_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  logic                hit;
  logic [IdxW-1:0]     hit_idx;
  logic [3:0]          hit_wait;
  logic                cur_hit;
  logic [IdxW-1:0]     cur_idx;
  logic                done;
  logic                rdy_int;
  logic [NSLV-1:0]     we_vec;

  // Write data goes straight from the CPU to the slaves; the decoder never looks at it.
  logic unused_dbw;
  assign unused_dbw = ^dbw;

  // Priority decode: the lowest matching index wins on overlapping windows.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_wait = '0;
    slv_sel  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (!hit && ((addr & MASK[i*ADDR_W +: ADDR_W]) ==
                   (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W]))) begin
        hit        = 1'b1;
        hit_idx    = IdxW'(i);
        hit_wait   = WAIT[i*4 +: 4];
        slv_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sel_vld_d  = sel_vld_q;
    sel_idx_d  = sel_idx_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    rdy_int    = 1'b1;
    done       = 1'b0;
    cur_hit    = hit;
    cur_idx    = hit_idx;
    we_vec     = '0;

    unique case (state_q)
      StIdle: begin
        if (hit && (hit_wait != 4'd0)) begin
          rdy_int = 1'b0;
          cnt_d   = hit_wait - 4'd1;
          idx_d   = hit_idx;
          state_d = StWait;
        end else begin
          done = 1'b1;
        end
      end
      StWait: begin
        // Slave index was latched on entry; addr is held by the stalled CPU.
        cur_hit = 1'b1;
        cur_idx = idx_q;
        if (cnt_q != 4'd0) begin
          rdy_int = 1'b0;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (done) begin
      sel_vld_d = cur_hit;
      sel_idx_d = cur_idx;
      if (we && cur_hit) begin
        we_vec[cur_idx] = 1'b1;
      end
    end

    // A new miss beats a simultaneous clear; otherwise the first fault is kept.
    if (done && !cur_hit && (!err_q || err_clr)) begin
      err_d      = 1'b1;
      err_addr_d = addr;
    end else if (err_clr && !(done && !cur_hit)) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      sel_vld_q  <= 1'b0;
      sel_idx_q  <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sel_vld_q  <= sel_vld_d;
      sel_idx_q  <= sel_idx_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    dbr = OPEN_BUS;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_vld_q && (sel_idx_q == IdxW'(i))) begin
        dbr = slv_dbr[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rdy      = rdy_int | ~rst;
  assign slv_we   = rst ? we_vec : '0;
  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Scoreboard bench for bus_decoder: the driver queues expected responses, a monitor
// checks stall count, write strobes and next-cycle read data on each completed access.
module tb_bus_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  dbw = 8'h00;
  logic        we = 1'b0;
  logic        rdy;
  logic [7:0]  dbr;
  logic [3:0]  slv_sel;
  logic [3:0]  slv_we;
  logic [31:0] slv_dbr = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
  logic        err;
  logic [15:0] err_addr;
  logic        err_clr = 1'b0;

  bus_decoder #(
    .NSLV    (4),
    .ADDR_W  (16),
    .DATA_W  (8),
    .BASE    ({16'h0234, 16'hFE20, 16'hFF00, 16'h0000}),
    .MASK    ({16'h0FFF, 16'hFFF0, 16'hFF00, 16'h8000}),
    .WAIT    ({4'd5, 4'd3, 4'd0, 4'd0}),
    .OPEN_BUS(8'hFF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .dbw     (dbw),
    .we      (we),
    .rdy     (rdy),
    .dbr     (dbr),
    .slv_sel (slv_sel),
    .slv_we  (slv_we),
    .slv_dbr (slv_dbr),
    .err     (err),
    .err_addr(err_addr),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dbr;
    int         stalls;
    logic [3:0] we;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_errs = 0;
  int         stalls = 0;
  logic       pend = 1'b0;
  logic [7:0] pend_dbr = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completing cycle (rdy=1) retires one queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      stalls = 0;
      pend   = 1'b0;
    end else begin
      if (pend) begin
        chk("dbr", {24'h0, dbr}, {24'h0, pend_dbr});
        pend = 1'b0;
      end
      if (!rdy) begin
        stalls++;
        chk("slv_we_in_stall", {28'h0, slv_we}, 32'h0);
      end else if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("stall_count", stalls, mon_e.stalls);
        chk("slv_we", {28'h0, slv_we}, {28'h0, mon_e.we});
        pend_dbr = mon_e.dbr;
        pend     = 1'b1;
        stalls   = 0;
      end else begin
        stalls = 0;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that ends the access.
  task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                        input logic clr, input logic [3:0] esel, input int est,
                        input logic [7:0] edbr);
    exp_t x;
    int   n;
    addr    = a;
    we      = w;
    dbw     = d;
    err_clr = clr;
    x.dbr    = edbr;
    x.stalls = est;
    x.we     = w ? esel : 4'b0000;
    sb.push_back(x);
    @(negedge clk);
    chk("slv_sel", {28'h0, slv_sel}, {28'h0, esel});
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      n_checks++;
      n_errs++;
      $display("FAIL rdy_timeout: addr %0h still stalled after %0d cycles", a, n);
    end
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", {31'h0, rdy}, 32'h1);
    chk("reset_dbr", {24'h0, dbr}, 32'hFF);
    chk("reset_slv_we", {28'h0, slv_we}, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    chk("reset_err_addr", {16'h0, err_addr}, 32'h0);
    chk("reset_slv_sel", {28'h0, slv_sel}, 32'h1);
    rst = 1'b1;

    access(16'hFF10, 1'b0, 8'h00, 1'b0, 4'b0010, 0, 8'hB1);
    access(16'hFE20, 1'b1, 8'h5A, 1'b0, 4'b0100, 3, 8'hC2);
    access(16'h0010, 1'b0, 8'h00, 1'b0, 4'b0001, 0, 8'hA0);

    access(16'hFE40, 1'b0, 8'h00, 1'b0, 4'b0000, 0, 8'hFF);
    chk("miss_err", {31'h0, err}, 32'h1);
    chk("miss_err_addr", {16'h0, err_addr}, 32'hFE40);
    access(16'hFE60, 1'b0, 8'h00, 1'b0, 4'b0000, 0, 8'hFF);
    chk("second_miss_err_addr", {16'h0, err_addr}, 32'hFE40);
    access(16'hFE80, 1'b1, 8'h11, 1'b1, 4'b0000, 0, 8'hFF);
    chk("clr_miss_err", {31'h0, err}, 32'h1);
    chk("clr_miss_err_addr", {16'h0, err_addr}, 32'hFE80);
    access(16'h0100, 1'b0, 8'h00, 1'b1, 4'b0001, 0, 8'hA0);
    chk("clr_err", {31'h0, err}, 32'h0);
    chk("clr_err_addr", {16'h0, err_addr}, 32'h0);

    access(16'h1234, 1'b0, 8'h00, 1'b0, 4'b0001, 0, 8'hA0);
    access(16'h8234, 1'b1, 8'h77, 1'b0, 4'b1000, 5, 8'hD3);

    // Abort a WAIT=5 write during its second stall cycle.
    addr = 16'h8234;
    we   = 1'b1;
    dbw  = 8'hEE;
    @(negedge clk);
    chk("abort_stall1_rdy", {31'h0, rdy}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_rdy", {31'h0, rdy}, 32'h1);
    chk("abort_dbr", {24'h0, dbr}, 32'hFF);
    chk("abort_slv_we", {28'h0, slv_we}, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("slv_we_in_reset", {28'h0, slv_we}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    access(16'h8234, 1'b0, 8'h00, 1'b0, 4'b1000, 5, 8'hD3);
    access(16'hFF10, 1'b0, 8'h00, 1'b0, 4'b0010, 0, 8'hB1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
